// File: rtl/fp32_to_int32.sv
// Two-stage FP32 -> signed int32 converter with ACT/TAG/RDY issue handshake.
// Define FP2I_ROUND_EN to round to nearest-even instead of truncating toward zero.
module fp32_to_int32 (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ACT,
  input  logic        TAGi,
  input  logic [31:0] A,
  output logic        RDY,
  output logic        TAGo,
  output logic [31:0] R,
  output logic        OVF
);

  logic        w_s;
  logic [7:0]  w_e;
  logic [22:0] w_frac;
  logic        w_nan, w_inf, w_zero, w_big, w_min, w_left;
  logic [7:0]  w_rdiff;
  logic [4:0]  w_shamt;

  logic        r_v1, r_tag1, r_s1;
  logic [23:0] r_m1;
  logic        r_nan1, r_inf1, r_zero1, r_big1, r_min1, r_left1;
  logic [4:0]  r_shamt1;

  assign w_s    = A[31];
  assign w_e    = A[30:23];
  assign w_frac = A[22:0];
  assign w_nan  = (&w_e) & (|w_frac);
  assign w_inf  = (&w_e) & ~(|w_frac);
  assign w_zero = (w_e == 8'd0);
  assign w_big  = (w_e >= 8'd158);
  // -2^31 is the one e=158 value that is representable
  assign w_min  = (w_e == 8'd158) & w_s & ~(|w_frac);
  assign w_left = (w_e >= 8'd150);
  assign w_rdiff = 8'd150 - w_e;

  always_comb begin
    w_shamt = 5'd0;
    if (w_left)
      w_shamt = 5'(w_e - 8'd150);
    else if (w_rdiff > 8'd31)
      w_shamt = 5'd31;
    else
      w_shamt = w_rdiff[4:0];
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_v1     <= 1'b0;
      r_tag1   <= 1'b0;
      r_s1     <= 1'b0;
      r_m1     <= 24'd0;
      r_nan1   <= 1'b0;
      r_inf1   <= 1'b0;
      r_zero1  <= 1'b0;
      r_big1   <= 1'b0;
      r_min1   <= 1'b0;
      r_left1  <= 1'b0;
      r_shamt1 <= 5'd0;
    end else begin
      r_v1 <= ACT;
      if (ACT) begin
        r_tag1   <= TAGi;
        r_s1     <= w_s;
        r_m1     <= {1'b1, w_frac};
        r_nan1   <= w_nan;
        r_inf1   <= w_inf;
        r_zero1  <= w_zero;
        r_big1   <= w_big;
        r_min1   <= w_min;
        r_left1  <= w_left;
        r_shamt1 <= w_shamt;
      end
    end
  end

  logic [31:0] w_lmag, w_rmag, w_mag, w_res;
  logic        w_ovf;

  assign w_lmag = {8'd0, r_m1} << r_shamt1;

`ifdef FP2I_ROUND_EN
  logic [47:0] w_rext;
  logic [31:0] w_rtrunc;
  logic        w_guard, w_sticky, w_inc;

  // significand extended by 24 fraction bits so guard/sticky survive the shift
  assign w_rext   = {r_m1, 24'd0} >> r_shamt1;
  assign w_rtrunc = {8'd0, w_rext[47:24]};
  assign w_guard  = w_rext[23];
  assign w_sticky = |w_rext[22:0];
  assign w_inc    = w_guard & (w_sticky | w_rtrunc[0]);
  assign w_rmag   = w_rtrunc + {31'd0, w_inc};
`else
  assign w_rmag = {8'd0, r_m1} >> r_shamt1;
`endif

  assign w_mag = r_left1 ? w_lmag : w_rmag;

  always_comb begin
    w_res = 32'd0;
    w_ovf = 1'b0;
    if (r_nan1) begin
      w_res = 32'h7FFF_FFFF;
      w_ovf = 1'b1;
    end else if (r_min1) begin
      w_res = 32'h8000_0000;
    end else if (r_inf1 || r_big1) begin
      w_res = r_s1 ? 32'h8000_0000 : 32'h7FFF_FFFF;
      w_ovf = 1'b1;
    end else if (r_zero1) begin
      w_res = 32'd0;
    end else begin
      w_res = r_s1 ? (~w_mag + 32'd1) : w_mag;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      RDY  <= 1'b0;
      TAGo <= 1'b0;
      R    <= 32'd0;
      OVF  <= 1'b0;
    end else begin
      RDY <= r_v1;
      if (r_v1) begin
        TAGo <= r_tag1;
        R    <= w_res;
        OVF  <= w_ovf;
      end
    end
  end

endmodule

// File: doc/fp32_to_int32.md
Name: fp32_to_int32

Overview:
- Pipelined converter from IEEE-754 single to signed 32-bit integer.
- Inverse direction of the FP adder/normaliser datapath: takes a normalised operand and de-normalises it to a fixed-point integer.
- Sits beside the FP32 add unit in the core's FP execution cluster.
- Uses the same ACT/TAG/RDY issue protocol: one operation accepted per clock, fixed latency, no back-pressure.

Parameters:
- none

Ports:
- CLK    in   1   clock; all state on rising edge
- RESET  in   1   asynchronous, active-low reset; clears all pipeline state
- ACT    in   1   operation issue strobe; A and TAGi sampled when high
- TAGi   in   1   caller tag, travels with the operation
- A      in   32  IEEE-754 single operand
- RDY    out  1   one-cycle strobe: R, OVF, TAGo valid
- TAGo   out  1   tag of the operation completing this cycle
- R      out  32  signed integer result; held until next RDY
- OVF    out  1   invalid/overflow flag for the completing operation; held with R

Behaviour:
- Reset (RESET=0, asynchronous) forces RDY=0, TAGo=0, OVF=0, R=0 and clears both stage valid bits.
  - Operations in flight are discarded; no RDY is produced for them.
  - ACT is ignored while RESET=0.
- Latency is 2. ACT in cycle n gives RDY=1 in cycle n+2 for exactly one cycle.
- Fully pipelined: ACT may be high every cycle. Results emerge in issue order with their own tags.
- Stage 1 (registered), from A:
  - sign s = A[31], exponent e = A[30:23], significand m = {1, A[22:0]}.
  - Class flags: zero/denormal (e=0), NaN, Inf, big (e>=158).
  - Shift direction and amount: left by e-150 when e>=150; right by 150-e otherwise, with the amount saturated at 31.
- Stage 2 (registered into R/OVF/TAGo/RDY only when stage-1 valid is set):
  - Magnitude is m shifted into a 32-bit field. Bits shifted out on a right shift are truncated (round toward zero).
  - e<127 (including denormal, zero, -0.0): R=0, OVF=0.
  - 127<=e<=157: R = s ? two's-complement negation of magnitude : magnitude; OVF=0.
  - e=158, s=1, A[22:0]=0 (exactly -2^31): R=0x80000000, OVF=0.
  - Any other e>=158 that is finite: R saturates to 0x7FFFFFFF (s=0) or 0x80000000 (s=1); OVF=1.
  - Inf: same saturation as the finite overflow case, by sign; OVF=1.
  - NaN (either sign): R=0x7FFFFFFF, OVF=1.
- When stage-1 valid is clear, RDY=0 and R/OVF/TAGo hold their previous values.
- The TAGi pipeline advances with valid only; TAGo is updated only on RDY.

Optional Feature:
- Macro: FP2I_ROUND_EN.
- Defined:
  - Stage 2 rounds to nearest, ties to even, using guard and sticky bits from the right shift.
  - e=126 participates: 0.5 gives 0, 0.75 gives 1.
  - Rounding is applied to the magnitude before negation.
  - No finite value below 2^31 can round up to overflow, because all such values with e>=151 are already integers.
  - Latency is unchanged.
- Undefined: truncation toward zero as described above; no guard/sticky logic is built.

Test Plan:
- Basic conversions: A=0x3F800000 (1.0) -> R=0x00000001, OVF=0, RDY exactly 2 cycles after ACT. A=0xC0200000 (-2.5) -> R=0xFFFFFFFE in both builds (-2 by truncation; -2 by ties-to-even with FP2I_ROUND_EN).
- Fraction rounding: A=0x3F400000 (0.75) -> R=0 without FP2I_ROUND_EN, R=1 with it.
- Boundaries:
  - A=0xCF000000 (-2^31) -> R=0x80000000, OVF=0.
  - A=0x4F000000 (+2^31) -> R=0x7FFFFFFF, OVF=1.
  - A=0x4F32D05E (~3e9) -> R=0x7FFFFFFF, OVF=1.
  - A=0x4EFFFFFF -> R=0x7FFFFF80, OVF=0.
- Specials:
  - A=0x7FC00000 (NaN) -> R=0x7FFFFFFF, OVF=1.
  - A=0xFF800000 (-Inf) -> R=0x80000000, OVF=1.
  - A=0x80000000 (-0.0) -> R=0, OVF=0.
  - A=0x00000001 (denormal) -> R=0, OVF=0.
- Streaming: ACT high 3 consecutive cycles with A=1.0, 2.0, 3.0 and TAGi=1,0,1 -> RDY high 3 consecutive cycles, R=1,2,3, TAGo=1,0,1. After that, R holds 3 while RDY=0.
- Reset mid-flight: issue 2 ops, assert RESET=0 one cycle later (asynchronously, mid-cycle) -> RDY, R, OVF, TAGo go to 0 immediately. No RDY appears after release. The next ACT completes normally 2 cycles later.
